mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before abort.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0 / req1  in  1 each  request from the entry requester (digit x10) / the calc requester (final product); held until done.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  16 each  operands, valid while the matching req is high.
REQ-006 SHALL have ports done0 / done1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-007 SHALL have port err  out  1  pulses with done when the transaction timed out.
REQ-008 SHALL have port result  out  16  product, valid in the done cycle and held until the next done.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have ports mult_in1, mult_in2  out  16 each  multiplier operands, registered.
REQ-011 SHALL have port start_mult  out  1  one-cycle start pulse to the multiplier.
REQ-012 SHALL have ports mult_out  in  16 and mult_finish  in  1  multiplier result and finish flag.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-014 IDLE: if req0 or req1 is high, SHALL choose a winner, latch its operands into mult_in1/mult_in2 and go to ISSUE; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a single request wins outright; with both requests high, the requester not served last wins.
REQ-016 ISSUE: SHALL assert start_mult for exactly one cycle, then go to WAIT.
REQ-017 mult_in1/mult_in2 SHALL stay stable from ISSUE through RESP.
REQ-018 WAIT: on mult_finish, SHALL latch mult_out into result and go to RESP with err=0.
REQ-019 WAIT: the cycle counter SHALL clear on entry and increment each cycle.
REQ-020 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without mult_finish, SHALL go to RESP with err=1 and result=0.
REQ-021 RESP: SHALL pulse done for the winner only, update the last-served pointer, then go to IDLE.
REQ-022 Latency: req sampled in IDLE at cycle N -> start_mult at N+1; mult_finish at cycle M -> done at M+1; minimum N+3.
REQ-023 mult_finish in IDLE, ISSUE or RESP SHALL be ignored.
REQ-024 mult_finish and timeout in the same cycle: finish SHALL win (err=0).
REQ-025 A req dropped mid-transaction SHALL NOT abort it; done still pulses.
REQ-026 A req still high in the cycle after done SHALL count as a new request.
REQ-027 Requests arriving while busy SHALL wait; none are lost while held.
REQ-028 Results SHALL be the unmodified 16-bit mult_out; no saturation or overflow flag.

Reset
REQ-029 RST high at a clock edge SHALL force IDLE from any state, including mid-transaction, with no done pulse.
REQ-030 On reset, all outputs (done0, done1, err, busy, start_mult, result, mult_in1, mult_in2) SHALL be 0.
REQ-031 On reset, the timeout counter SHALL be 0 and the last-served pointer SHALL be requester 1, so req0 wins the first tie.

Structure
REQ-032 SHALL place arb_state_t (IDLE, ISSUE, WAIT, RESP), requester ID constants and the TIMEOUT_CYCLES default in shared package calc_pkg.
REQ-033 The round-robin pick SHALL be a combinational sub-module rr_arb2 (inputs: req[1:0], last; output: grant index); FSM and counter stay in mult_arbiter.

Verification
REQ-034 req0=1 (a=12, b=10); multiplier model returns finish 3 cycles after start -> start_mult one cycle at N+1, mult_in1=12, mult_in2=10, done0 at N+5, result=120, err=0, done1 never.
REQ-035 req0 and req1 rise together (0x0003x0x0007, 0x0005x0x0009) -> req0 served first (result 21), req1 next (result 45), one transaction apart, done pulses never overlap.
REQ-036 Both requests held continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-037 Multiplier never asserts finish, TIMEOUT_CYCLES=8 -> done plus err=1 exactly 8 cycles after entering WAIT, result=0; FSM back in IDLE.
REQ-038 RST pulsed one cycle during WAIT -> next cycle IDLE, all outputs 0, no done. A finish arriving after the reset is ignored. A following req1 completes normally.
REQ-039 Stray mult_finish in IDLE, and finish coinciding with the timeout cycle -> the stray is ignored; the coinciding case yields err=0 with result=mult_out.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM states,
// requester IDs and the default WAIT-state timeout.
package calc_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam logic REQ_ID0 = 1'b0;  // entry requester (digit x10)
  localparam logic REQ_ID1 = 1'b1;  // calc requester (final product)

  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier-side signals of the arbiter; slave is the
// arbiter's view, master is the environment's view.
interface mult_arbiter_if;
  logic        req0, req1;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        done0, done1, err;
  logic [15:0] result;
  logic        busy;
  logic [15:0] mult_in1, mult_in2;
  logic        start_mult;
  logic [15:0] mult_out;
  logic        mult_finish;

  modport slave (
    input  req0, req1, req0_a, req0_b, req1_a, req1_b, mult_out, mult_finish,
    output done0, done1, err, result, busy, mult_in1, mult_in2, start_mult
  );

  modport master (
    output req0, req1, req0_a, req0_b, req1_a, req1_b, mult_out, mult_finish,
    input  done0, done1, err, result, busy, mult_in1, mult_in2, start_mult
  );
endinterface

// File: rtl/mult_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the
// requester that was not served last.
module rr_arb2
  import calc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);
  always_comb begin
    grant = REQ_ID0;
    if (req == 2'b11) grant = ~last;
    else if (req[1])  grant = REQ_ID1;
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one multi-cycle multiplier between two requesters with round-robin
// arbitration and a WAIT-state timeout that returns err=1, result=0.
module mult_arbiter
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           RST,
  mult_arbiter_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic [15:0]   in1_q, in1_d, in2_q, in2_d;
  logic [15:0]   result_q, result_d;
  logic          start_q, start_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err_q, err_d;
  logic          grant;

  rr_arb2 u_rr (
    .req   ({bus.req1, bus.req0}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    last_d   = last_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;
    start_d  = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d   = grant;
          in1_d   = (grant == REQ_ID1) ? bus.req1_a : bus.req0_a;
          in2_d   = (grant == REQ_ID1) ? bus.req1_b : bus.req0_b;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // finish beats a timeout landing in the same cycle
        if (bus.mult_finish) begin
          result_d = bus.mult_out;
          done0_d  = (win_q == REQ_ID0);
          done1_d  = (win_q == REQ_ID1);
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          done0_d  = (win_q == REQ_ID0);
          done1_d  = (win_q == REQ_ID1);
          state_d  = RESP;
        end
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= REQ_ID0;
      last_q   <= REQ_ID1;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      last_q   <= last_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      result_q <= result_d;
      start_q  <= start_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err_q    <= err_d;
    end
  end

  assign bus.mult_in1   = in1_q;
  assign bus.mult_in2   = in2_q;
  assign bus.start_mult = start_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.err        = err_q;
  assign bus.result     = result_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: table of single transactions plus
// hand-written sequences for alternation, stray finish and mid-WAIT reset.
module tb_mult_arbiter;
  import calc_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_arbiter_if bus();

  mult_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Multiplier model: finish m_dly cycles after start (0 = never answers)
  int          m_dly = 0;
  int          m_cnt = 0;
  bit          m_act = 0;
  logic [15:0] m_prod = '0;
  int          stray_n = 0;
  int          stray_seen = 0;

  always @(negedge clk) begin
    bus.mult_finish = 1'b0;
    if (stray_n != stray_seen) begin
      stray_seen      = stray_n;
      bus.mult_finish = 1'b1;
      bus.mult_out    = 16'hDEAD;
    end
    if (m_act) begin
      m_cnt++;
      if (m_cnt == m_dly) begin
        bus.mult_finish = 1'b1;
        bus.mult_out    = m_prod;
        m_act           = 1'b0;
      end
    end
    if (bus.start_mult) begin
      m_act = (m_dly != 0);
      m_cnt = 0;
    end
  end

  typedef struct {
    logic        r0, r1;
    logic [15:0] a0, b0, a1, b1;
    int          dly;
    logic [15:0] prod;
    logic        g;
    logic [15:0] e_in1, e_in2, e_res;
    logic        e_err;
  } vec_t;

  vec_t vt[8];
  vec_t vr;

  // Entered on a negedge while the FSM is IDLE; leaves on the IDLE negedge after done.
  task automatic run_vec(input vec_t v, input int idx);
    int n, k, exp_lat;
    bus.req0 = v.r0;  bus.req1 = v.r1;
    bus.req0_a = v.a0; bus.req0_b = v.b0;
    bus.req1_a = v.a1; bus.req1_b = v.b1;
    m_dly = v.dly; m_prod = v.prod;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.start_mult && n < 20);
    chk($sformatf("v%0d start_lat", idx), n, 1);
    chk($sformatf("v%0d mult_in1", idx), bus.mult_in1, v.e_in1);
    chk($sformatf("v%0d mult_in2", idx), bus.mult_in2, v.e_in2);
    @(negedge clk);
    chk($sformatf("v%0d start_one_cycle", idx), {bus.start_mult, bus.busy}, 2'b01);
    k = 1;
    while (!(bus.done0 || bus.done1) && k < 30) begin @(negedge clk); k++; end
    exp_lat = (v.dly == 0) ? TO + 1 : v.dly + 1;
    chk($sformatf("v%0d done_lat", idx), k, exp_lat);
    chk($sformatf("v%0d done{1,0}", idx), {bus.done1, bus.done0}, v.g ? 2'b10 : 2'b01);
    chk($sformatf("v%0d result", idx), bus.result, v.e_res);
    chk($sformatf("v%0d err", idx), bus.err, v.e_err);
    chk($sformatf("v%0d in_stable", idx), {bus.mult_in1, bus.mult_in2}, {v.e_in1, v.e_in2});
    if (v.g) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle_after", idx), {bus.busy, bus.done1, bus.done0, bus.err}, 4'b0);
  endtask

  initial begin
    int c;
    logic bad;
    //                r0 r1  a0       b0       a1        b1       dly prod      g  in1      in2      res       err
    vt[0] = '{1'b1, 1'b1, 16'd3,   16'd7,   16'd5,    16'd9,   2, 16'd21,   1'b0, 16'd3,   16'd7,   16'd21,   1'b0};
    vt[1] = '{1'b0, 1'b1, 16'd3,   16'd7,   16'd5,    16'd9,   4, 16'd45,   1'b1, 16'd5,   16'd9,   16'd45,   1'b0};
    vt[2] = '{1'b1, 1'b0, 16'd12,  16'd10,  16'd0,    16'd0,   3, 16'd120,  1'b0, 16'd12,  16'd10,  16'd120,  1'b0};
    vt[3] = '{1'b1, 1'b1, 16'd3,   16'd3,   16'hFFFF, 16'd2,   1, 16'hFFFE, 1'b1, 16'hFFFF,16'd2,   16'hFFFE, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'd3,   16'd3,   16'd0,    16'd0,   0, 16'h1234, 1'b0, 16'd3,   16'd3,   16'd0,    1'b1};
    vt[5] = '{1'b0, 1'b1, 16'd0,   16'd0,   16'd7,    16'd9,   8, 16'd63,   1'b1, 16'd7,   16'd9,   16'd63,   1'b0};
    vt[6] = '{1'b1, 1'b1, 16'd2,   16'd2,   16'd4,    16'd4,   7, 16'd4,    1'b0, 16'd2,   16'd2,   16'd4,    1'b0};
    vt[7] = '{1'b0, 1'b1, 16'd2,   16'd2,   16'd4,    16'd4,   1, 16'd16,   1'b1, 16'd4,   16'd4,   16'd16,   1'b0};
    vr    = '{1'b0, 1'b1, 16'd0,   16'd0,   16'd6,    16'd7,   2, 16'd42,   1'b1, 16'd6,   16'd7,   16'd42,   1'b0};

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {bus.done0, bus.done1, bus.err, bus.busy, bus.start_mult}, 5'b0);
    chk("rst_result", bus.result, 16'd0);
    chk("rst_mult_in", {bus.mult_in1, bus.mult_in2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);

    // stray finish while IDLE must be ignored
    stray_n++;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.done0 || bus.done1 || bus.err || bus.result != 16'd0) bad = 1'b1;
    end
    chk("stray_finish_idle", bad, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // both held: grants alternate 0,1,0,1 starting from reset
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    m_dly = 2; m_prod = 16'h0055;
    bus.req0_a = 16'd2; bus.req0_b = 16'd3; bus.req1_a = 16'd4; bus.req1_b = 16'd5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = 0;
      do begin @(negedge clk); c++; end while (!(bus.done0 || bus.done1) && c < 40);
      chk($sformatf("alt%0d done_seen", i), bus.done0 | bus.done1, 1'b1);
      chk($sformatf("alt%0d grant", i), {bus.done1, bus.done0}, (i % 2) ? 2'b10 : 2'b01);
      if (i == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    repeat (2) @(negedge clk);
    chk("alt_idle", bus.busy, 1'b0);

    // reset pulse during WAIT, late finish ignored, then req1 completes
    m_dly = 5; m_prod = 16'h0077;
    bus.req0_a = 16'd4; bus.req0_b = 16'd4; bus.req0 = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.start_mult && c < 20);
    chk("rw start_seen", bus.start_mult, 1'b1);
    repeat (2) @(negedge clk);
    chk("rw in_wait", bus.busy, 1'b1);
    rst = 1'b1; bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rw flags", {bus.done0, bus.done1, bus.err, bus.busy, bus.start_mult}, 5'b0);
    chk("rw result", bus.result, 16'd0);
    chk("rw mult_in", {bus.mult_in1, bus.mult_in2}, 32'd0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done0 || bus.done1 || bus.err) bad = 1'b1;
    end
    chk("rw late_finish_ignored", bad, 1'b0);
    run_vec(vr, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
